uart_param_core: RTL and testbench
==================================

# uart_param_core

Parametrised full-duplex UART core and the next generation of `uart_top`. It has a configurable data width, optional even/odd parity, one or two stop bits, majority-vote receive sampling, and parity/framing error reporting. It sits between a byte-level host interface and the serial pins. `tx_line` may be looped back to `rx_line` for self-test.

## Interface
- `clk_freq`, 1000000, system clock frequency in Hz.
- `baud_rate`, 9600, line rate. `BIT_CYCLES = clk_freq / baud_rate`, truncated. BIT_CYCLES ≥ 8 is required.
- `data_bits`, 8, payload width. Legal range is 5..9.
- `parity`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `stop_bits`, 1, transmitted stop bits: 1 or 2.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  in  data_bits  word to send, captured on accept.
- `tx_send`  in  1  send request, level-sampled.
- `tx_busy`  out  1  transmitter frame in progress.
- `tx_line`  out  1  serial output, idle high.
- `rx_line`  in  1  serial input, asynchronous to `clk`.
- `rx_data`  out  data_bits  last received word.
- `rx_ready`  out  1  one-cycle pulse: a new word is in `rx_data`.
- `rx_parity_err`  out  1  parity mismatch for the word in `rx_data`.
- `rx_frame_err`  out  1  first stop bit was sampled low for the word in `rx_data`.

## Operation
- **Reset** (`reset` low, asynchronous):
  - `tx_line` = 1; `tx_busy`, `rx_ready`, `rx_parity_err`, `rx_frame_err` = 0; `rx_data` = 0.
  - Synchroniser flops = 1; both FSMs go to IDLE.
  - Reset mid-frame aborts immediately. The partial frame is discarded.
- **TX FSM** IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when `parity` = 0.
  - Each state lasts BIT_CYCLES, counted by a bit-cycle counter. STOP lasts stop_bits × BIT_CYCLES.
  - Accept: `tx_send` = 1 while in IDLE. `tx_data` is latched into a shift register.
  - Data is sent LSB first.
  - Parity bit = XOR of the data bits for even; its inverse for odd.
  - `tx_send` while busy is ignored; there is no queue.
  - `tx_send` held high at frame end starts the next frame in the cycle after `tx_busy` falls.
- **RX front end:** two-flop synchroniser on `rx_line`. All RX logic uses the synchronised value `rxs`.
- **RX FSM** IDLE → START → DATA → PARITY → STOP → (WAIT_HIGH) → IDLE.
  - Start is detected at edge E, when `rxs` goes high→low in IDLE. The bit-cycle counter restarts at E.
  - Sample points per bit are offsets h−1, h, h+1 from bit start, with h = BIT_CYCLES/2. The bit value is the 2-of-3 majority.
  - START: a majority of 1 is a false start; return to IDLE with no pulse and no flag change.
  - DATA: shift LSB first.
  - PARITY: recompute parity and compare against the received bit.
  - STOP: only the first stop bit is checked, so back-to-back frames with one stop bit are received.
  - After the first stop bit is decided: `rx_data`, `rx_parity_err` and `rx_frame_err` update, and `rx_ready` pulses for exactly 1 cycle.
  - If the stop bit was 0 (framing error or break), enter WAIT_HIGH. The FSM re-arms only once `rxs` = 1.
- **Outputs:**
  - `rx_data` and both error flags hold until the next `rx_ready`.
  - For 9-bit words, `rx_data[8]` is the MSB received last.
  - `rx_parity_err` is always 0 when `parity` = 0.

## Timing
- TX:
  - At accept edge N, `tx_line` goes 0 and `tx_busy` goes 1. Both are registered with no extra latency.
  - FRAME = BIT_CYCLES × (1 + data_bits + (parity≠0) + stop_bits).
  - `tx_busy` falls at edge N + FRAME, and `tx_line` is 1 from N + FRAME − stop_bits × BIT_CYCLES onward.
- RX:
  - E = first `rx_line` low + 2 or 3 cycles (synchroniser).
  - `rx_ready` is high for the cycle starting at edge E + (1 + data_bits + (parity≠0)) × BIT_CYCLES + h + 2.
- TX and RX are independent. Simultaneous accept and receive are both honoured.
- Width rules:
  - Counters are sized `$clog2(BIT_CYCLES)`.
  - The bit index is sized `$clog2(data_bits + 1)`.
  - Counters never wrap within a bit.

## Test plan
All scenarios use `clk_freq` = 1000000, `baud_rate` = 9600 (BIT_CYCLES = 104), with loopback unless stated.

- **8N1 loopback:** send 0x55, 0xAA, 0x00, 0xFF in sequence.
  - Each returns the same value with both error flags 0.
  - `tx_busy` is high for exactly 1040 cycles.
  - `rx_ready` occurs 992–993 cycles after accept.
- **Even parity** (`parity` = 1, `stop_bits` = 2, `data_bits` = 7): send 0x41.
  - Parity bit on the line = 0.
  - `tx_busy` is high for 1144 cycles.
  - `rx_data` = 0x41, `rx_parity_err` = 0.
- **Odd parity, forced error** (`parity` = 2, bench drives `rx_line`): send the frame for 0x3C with a wrong parity bit.
  - `rx_data` = 0x3C, `rx_parity_err` = 1.
  - The next clean frame clears the flag.
- **Noise and glitches** (bench drives `rx_line`):
  - A 3-cycle low glitch produces no `rx_ready`.
  - A single-cycle inverted pulse at the mid-bit sample point is rejected by the majority vote: 0xA5 is still received correctly.
- **Framing and break:**
  - Stop bit driven low: `rx_frame_err` = 1.
  - Line then held low for 3000 cycles: no further `rx_ready`.
  - After the line goes high, 0x5A is received with `rx_frame_err` = 0.
- **Reset and accept rules:**
  - `reset` asserted mid-frame at bit 4: `tx_line` = 1 and `tx_busy` = 0 immediately; no `rx_ready`.
  - `tx_send` pulsed during a busy frame is ignored.
  - `tx_send` held high produces back-to-back frames with no idle gap.

Source files
------------

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: configurable width, optional parity, 1/2 stop bits,
// 2-of-3 majority receive sampling with parity and framing error reporting.
module uart_param_core #(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600,
  parameter int unsigned data_bits = 8,
  parameter int unsigned parity    = 0,
  parameter int unsigned stop_bits = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_bits-1:0] tx_data,
  input  logic                 tx_send,
  output logic                 tx_busy,
  output logic                 tx_line,
  input  logic                 rx_line,
  output logic [data_bits-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int unsigned BIT_CYCLES = clk_freq / baud_rate;
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES);
  localparam int unsigned IDX_W      = $clog2(data_bits + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_S0    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(HALF + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(data_bits - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(stop_bits - 1);
  localparam logic             PAR_EN    = (parity != 0);
  localparam logic             PAR_ODD   = (parity == 2);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t              tx_state, tx_state_nxt;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_nxt;
  logic [IDX_W-1:0]       tx_idx, tx_idx_nxt;
  logic [data_bits-1:0]   tx_shift, tx_shift_nxt;
  logic                   tx_par, tx_par_nxt;
  logic                   tx_line_nxt, tx_busy_nxt;
  logic                   tx_bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
      tx_line  <= tx_line_nxt;
      tx_busy  <= tx_busy_nxt;
    end
  end

  // Line and busy are computed one edge ahead so they change exactly on state edges.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_line_nxt  = tx_line;
    tx_busy_nxt  = tx_busy;
    tx_bit_end   = (tx_cnt == CNT_LAST);

    if (tx_state != TX_IDLE) begin
      tx_cnt_nxt = tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
    end

    case (tx_state)
      TX_IDLE: begin
        tx_line_nxt = 1'b1;
        tx_busy_nxt = 1'b0;
        if (tx_send) begin
          tx_state_nxt = TX_START;
          tx_cnt_nxt   = '0;
          tx_shift_nxt = tx_data;
          tx_par_nxt   = (^tx_data) ^ PAR_ODD;
          tx_line_nxt  = 1'b0;
          tx_busy_nxt  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_nxt = TX_DATA;
          tx_idx_nxt   = '0;
          tx_line_nxt  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_nxt = tx_shift >> 1;
          if (tx_idx == IDX_LAST) begin
            tx_idx_nxt = '0;
            if (PAR_EN) begin
              tx_state_nxt = TX_PARITY;
              tx_line_nxt  = tx_par;
            end else begin
              tx_state_nxt = TX_STOP;
              tx_line_nxt  = 1'b1;
            end
          end else begin
            tx_idx_nxt  = tx_idx + IDX_W'(1);
            tx_line_nxt = tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_nxt = TX_STOP;
          tx_idx_nxt   = '0;
          tx_line_nxt  = 1'b1;
        end
      end
      TX_STOP: begin
        // The bit index doubles as the stop-bit counter.
        if (tx_bit_end) begin
          if (tx_idx == STOP_LAST) begin
            tx_state_nxt = TX_IDLE;
            tx_busy_nxt  = 1'b0;
          end else begin
            tx_idx_nxt = tx_idx + IDX_W'(1);
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic rx_meta, rxs, rxs_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t              rx_state, rx_state_nxt;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
  logic [IDX_W-1:0]       rx_idx, rx_idx_nxt;
  logic [data_bits-1:0]   rx_shift, rx_shift_nxt;
  logic                   rx_s0, rx_s0_nxt, rx_s1, rx_s1_nxt;
  logic                   rx_par_bit, rx_par_bit_nxt;
  logic [data_bits-1:0]   rx_data_nxt;
  logic                   rx_ready_nxt, rx_perr_nxt, rx_ferr_nxt;
  logic                   rx_bit_end, rx_mid, rx_vote;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_s0         <= 1'b1;
      rx_s1         <= 1'b1;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_state_nxt;
      rx_cnt        <= rx_cnt_nxt;
      rx_idx        <= rx_idx_nxt;
      rx_shift      <= rx_shift_nxt;
      rx_s0         <= rx_s0_nxt;
      rx_s1         <= rx_s1_nxt;
      rx_par_bit    <= rx_par_bit_nxt;
      rx_data       <= rx_data_nxt;
      rx_ready      <= rx_ready_nxt;
      rx_parity_err <= rx_perr_nxt;
      rx_frame_err  <= rx_ferr_nxt;
    end
  end

  // rx_cnt equals cycles since the start of the current bit; the start bit begins at the detected edge.
  always_comb begin
    rx_state_nxt   = rx_state;
    rx_cnt_nxt     = rx_cnt;
    rx_idx_nxt     = rx_idx;
    rx_shift_nxt   = rx_shift;
    rx_s0_nxt      = rx_s0;
    rx_s1_nxt      = rx_s1;
    rx_par_bit_nxt = rx_par_bit;
    rx_data_nxt    = rx_data;
    rx_ready_nxt   = 1'b0;
    rx_perr_nxt    = rx_parity_err;
    rx_ferr_nxt    = rx_frame_err;
    rx_bit_end     = (rx_cnt == CNT_LAST);
    rx_mid         = (rx_cnt == CNT_MID);
    rx_vote        = (rx_s0 & rx_s1) | (rx_s0 & rxs) | (rx_s1 & rxs);

    if (rx_state != RX_IDLE && rx_state != RX_WAIT_HIGH) begin
      rx_cnt_nxt = rx_bit_end ? '0 : rx_cnt + CNT_W'(1);
      if (rx_cnt == CNT_S0) rx_s0_nxt = rxs;
      if (rx_cnt == CNT_S1) rx_s1_nxt = rxs;
    end

    case (rx_state)
      RX_IDLE: begin
        if (!rxs && rxs_d) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = CNT_W'(1);
        end
      end
      RX_START: begin
        if (rx_mid && rx_vote) begin
          rx_state_nxt = RX_IDLE;
        end else if (rx_bit_end) begin
          rx_state_nxt = RX_DATA;
          rx_idx_nxt   = '0;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_nxt = {rx_vote, rx_shift[data_bits-1:1]};
        if (rx_bit_end) begin
          if (rx_idx == IDX_LAST) begin
            rx_state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_nxt = rx_idx + IDX_W'(1);
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid) rx_par_bit_nxt = rx_vote;
        if (rx_bit_end) rx_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        // Decide at the first stop bit's last sample so back-to-back frames are caught.
        if (rx_mid) begin
          rx_data_nxt  = rx_shift;
          rx_ready_nxt = 1'b1;
          rx_ferr_nxt  = ~rx_vote;
          rx_perr_nxt  = PAR_EN & (rx_par_bit != ((^rx_shift) ^ PAR_ODD));
          rx_state_nxt = rx_vote ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxs) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: 8N1 loopback, 7E2 loopback and an 8O1 receiver
// driven from the bench, covering timing, parity, glitches, framing, reset and accept rules.
module tb_uart_param_core;

  localparam int BC = 104;
  localparam int H  = 52;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT A: 8N1, loopback or bench-driven receive
  logic [7:0] tx_data_a = '0;
  logic       tx_send_a = 1'b0, tx_busy_a, tx_line_a, rx_ready_a, rx_perr_a, rx_ferr_a;
  logic [7:0] rx_data_a;
  logic       loop_a = 1'b1, rx_bench_a = 1'b1;
  logic       rx_line_a;
  assign rx_line_a = loop_a ? tx_line_a : rx_bench_a;

  // DUT B: 7 data bits, even parity, two stop bits, loopback
  logic [6:0] tx_data_b = '0;
  logic       tx_send_b = 1'b0, tx_busy_b, tx_line_b, rx_ready_b, rx_perr_b, rx_ferr_b;
  logic [6:0] rx_data_b;

  // DUT C: 8 data bits, odd parity, receive driven by the bench
  logic [7:0] tx_data_c = '0;
  logic       tx_send_c = 1'b0, tx_busy_c, tx_line_c, rx_ready_c, rx_perr_c, rx_ferr_c;
  logic [7:0] rx_data_c;
  logic       rx_c = 1'b1;

  uart_param_core u_a (
    .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_send(tx_send_a),
    .tx_busy(tx_busy_a), .tx_line(tx_line_a), .rx_line(rx_line_a),
    .rx_data(rx_data_a), .rx_ready(rx_ready_a), .rx_parity_err(rx_perr_a),
    .rx_frame_err(rx_ferr_a));

  uart_param_core #(.data_bits(7), .parity(1), .stop_bits(2)) u_b (
    .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_send(tx_send_b),
    .tx_busy(tx_busy_b), .tx_line(tx_line_b), .rx_line(tx_line_b),
    .rx_data(rx_data_b), .rx_ready(rx_ready_b), .rx_parity_err(rx_perr_b),
    .rx_frame_err(rx_ferr_b));

  uart_param_core #(.parity(2)) u_c (
    .clk(clk), .reset(reset), .tx_data(tx_data_c), .tx_send(tx_send_c),
    .tx_busy(tx_busy_c), .tx_line(tx_line_c), .rx_line(rx_c),
    .rx_data(rx_data_c), .rx_ready(rx_ready_c), .rx_parity_err(rx_perr_c),
    .rx_frame_err(rx_ferr_c));

  // Edge/pulse monitor, sampled mid-cycle
  int rise_a = 0, fall_a = 0, rise_b = 0, fall_b = 0;
  int rdy_a = 0, rdy_b = 0, rdy_c = 0, rdy_cyc_a = 0;
  logic busy_a_q = 1'b0, busy_b_q = 1'b0;
  always @(negedge clk) begin
    if (tx_busy_a && !busy_a_q) rise_a = cyc;
    if (!tx_busy_a && busy_a_q) fall_a = cyc;
    busy_a_q = tx_busy_a;
    if (tx_busy_b && !busy_b_q) rise_b = cyc;
    if (!tx_busy_b && busy_b_q) fall_b = cyc;
    busy_b_q = tx_busy_b;
    if (rx_ready_a) begin rdy_a++; rdy_cyc_a = cyc; end
    if (rx_ready_b) rdy_b++;
    if (rx_ready_c) rdy_c++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, output int acc);
    tx_data_a = d;
    tx_send_a = 1'b1;
    wait_cyc(1);
    tx_send_a = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (tx_busy_a && n < budget) begin wait_cyc(1); n++; end
    check("idle_timeout_a", 32'(tx_busy_a), 32'd0);
    wait_cyc(2);
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    while (tx_busy_b && n < budget) begin wait_cyc(1); n++; end
    check("idle_timeout_b", 32'(tx_busy_b), 32'd0);
    wait_cyc(2);
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_bench_a = v;
    else          rx_c = v;
  endtask

  // One frame on a bench-driven line; glitch_bit selects a data bit to invert for one cycle mid-bit.
  task automatic drive_frame(input int sel, input logic [7:0] d, input bit par_en,
                             input logic par_bit, input logic stop_v, input logic idle_v,
                             input int glitch_bit);
    logic v;
    set_rx(sel, 1'b0);
    wait_cyc(BC);
    for (int i = 0; i < 8; i++) begin
      v = d[i];
      set_rx(sel, v);
      if (i == glitch_bit) begin
        wait_cyc(H);
        set_rx(sel, ~v);
        wait_cyc(1);
        set_rx(sel, v);
        wait_cyc(BC - H - 1);
      end else begin
        wait_cyc(BC);
      end
    end
    if (par_en) begin
      set_rx(sel, par_bit);
      wait_cyc(BC);
    end
    set_rx(sel, stop_v);
    wait_cyc(BC);
    set_rx(sel, idle_v);
  endtask

  initial begin
    logic [7:0] vec [4];
    logic [6:0] db;
    int acc, acc2, lat, prev;
    vec[0] = 8'h55; vec[1] = 8'hAA; vec[2] = 8'h00; vec[3] = 8'hFF;

    // Reset state
    #2 reset = 1'b0;
    wait_cyc(3);
    check("rst_tx_line", 32'(tx_line_a), 32'd1);
    check("rst_tx_busy", 32'(tx_busy_a), 32'd0);
    check("rst_rx_ready", 32'(rx_ready_a), 32'd0);
    check("rst_rx_data", 32'(rx_data_a), 32'd0);
    check("rst_errs", 32'({rx_perr_a, rx_ferr_a}), 32'd0);
    reset = 1'b1;
    wait_cyc(5);

    // 8N1 loopback
    for (int k = 0; k < 4; k++) begin
      prev = rdy_a;
      send_a(vec[k], acc);
      check("accept_line", 32'(tx_line_a), 32'd0);
      check("accept_busy", 32'(tx_busy_a), 32'd1);
      wait_idle_a(2000);
      check("busy_rise", 32'(rise_a), 32'(acc));
      check("busy_len", 32'(fall_a - rise_a), 32'd1040);
      check("rdy_count", 32'(rdy_a - prev), 32'd1);
      lat = rdy_cyc_a - acc;
      check("rx_latency", 32'((lat == 993) ? 992 : lat), 32'd992);
      check("rx_data", 32'(rx_data_a), 32'(vec[k]));
      check("rx_errs", 32'({rx_perr_a, rx_ferr_a}), 32'd0);
    end

    // 7E2 loopback, 0x41: parity bit 0
    db = 7'h41;
    tx_data_b = db;
    tx_send_b = 1'b1;
    wait_cyc(1);
    tx_send_b = 1'b0;
    wait_cyc(H);
    check("b_start_bit", 32'(tx_line_b), 32'd0);
    for (int i = 0; i < 7; i++) begin
      wait_cyc(BC);
      check("b_data_bit", 32'(tx_line_b), 32'(db[i]));
    end
    wait_cyc(BC);
    check("b_parity_bit", 32'(tx_line_b), 32'd0);
    wait_cyc(BC);
    check("b_stop_bit", 32'(tx_line_b), 32'd1);
    wait_idle_b(2000);
    check("b_busy_len", 32'(fall_b - rise_b), 32'd1144);
    check("b_rdy_count", 32'(rdy_b), 32'd1);
    check("b_rx_data", 32'(rx_data_b), 32'h41);
    check("b_errs", 32'({rx_perr_b, rx_ferr_b}), 32'd0);

    // 8O1 receive: 0x3C needs parity 1, send 0
    drive_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    wait_cyc(20);
    check("c_rdy_count", 32'(rdy_c), 32'd1);
    check("c_rx_data", 32'(rx_data_c), 32'h3C);
    check("c_parity_err", 32'(rx_perr_c), 32'd1);
    check("c_frame_err", 32'(rx_ferr_c), 32'd0);
    wait_cyc(100);
    check("c_perr_hold", 32'(rx_perr_c), 32'd1);
    // 0x07 has three ones: odd parity bit 0
    drive_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    wait_cyc(20);
    check("c_rdy_count2", 32'(rdy_c), 32'd2);
    check("c_rx_data2", 32'(rx_data_c), 32'h07);
    check("c_parity_clr", 32'(rx_perr_c), 32'd0);
    check("c_tx_idle", 32'({tx_busy_c, tx_line_c}), 32'd1);

    // Glitches on A
    loop_a = 1'b0;
    rx_bench_a = 1'b1;
    wait_cyc(10);
    prev = rdy_a;
    rx_bench_a = 1'b0;
    wait_cyc(3);
    rx_bench_a = 1'b1;
    wait_cyc(300);
    check("glitch_no_rdy", 32'(rdy_a - prev), 32'd0);
    drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    wait_cyc(20);
    check("mid_glitch_rdy", 32'(rdy_a - prev), 32'd1);
    check("mid_glitch_data", 32'(rx_data_a), 32'hA5);
    check("mid_glitch_errs", 32'({rx_perr_a, rx_ferr_a}), 32'd0);

    // Framing error then break
    prev = rdy_a;
    drive_frame(0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("frame_rdy", 32'(rdy_a - prev), 32'd1);
    check("frame_err", 32'(rx_ferr_a), 32'd1);
    check("frame_data", 32'(rx_data_a), 32'h33);
    wait_cyc(3000);
    check("break_no_rdy", 32'(rdy_a - prev), 32'd1);
    rx_bench_a = 1'b1;
    wait_cyc(50);
    drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    wait_cyc(20);
    check("recover_rdy", 32'(rdy_a - prev), 32'd2);
    check("recover_data", 32'(rx_data_a), 32'h5A);
    check("recover_ferr", 32'(rx_ferr_a), 32'd0);

    // tx_send during a busy frame is ignored
    loop_a = 1'b1;
    wait_cyc(10);
    prev = rdy_a;
    send_a(8'h12, acc);
    wait_cyc(300);
    tx_data_a = 8'h34;
    tx_send_a = 1'b1;
    wait_cyc(1);
    tx_send_a = 1'b0;
    wait_idle_a(2000);
    check("ignore_len", 32'(fall_a - acc), 32'd1040);
    wait_cyc(20);
    check("ignore_busy", 32'(tx_busy_a), 32'd0);
    check("ignore_rdy", 32'(rdy_a - prev), 32'd1);
    check("ignore_data", 32'(rx_data_a), 32'h12);

    // tx_send held high: next frame starts the cycle after busy falls
    prev = rdy_a;
    tx_data_a = 8'h81;
    tx_send_a = 1'b1;
    wait_cyc(1);
    acc = cyc;
    tx_data_a = 8'h7E;
    wait_idle_a(2000);
    check("held_first_len", 32'(fall_a - acc), 32'd1040);
    check("held_restart_busy", 32'(tx_busy_a), 32'd1);
    check("held_gap", 32'(rise_a - fall_a), 32'd1);
    check("held_first_data", 32'(rx_data_a), 32'h81);
    acc2 = rise_a;
    tx_send_a = 1'b0;
    wait_idle_a(2000);
    check("held_second_len", 32'(fall_a - acc2), 32'd1040);
    check("held_second_data", 32'(rx_data_a), 32'h7E);
    check("held_rdy", 32'(rdy_a - prev), 32'd2);

    // Reset mid-frame at data bit 4
    wait_cyc(10);
    prev = rdy_a;
    send_a(8'hC3, acc);
    wait_cyc(5 * BC + H);
    reset = 1'b0;
    #1;
    check("midrst_line", 32'(tx_line_a), 32'd1);
    check("midrst_busy", 32'(tx_busy_a), 32'd0);
    check("midrst_rx_data", 32'(rx_data_a), 32'd0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(1200);
    check("midrst_no_rdy", 32'(rdy_a - prev), 32'd0);
    check("midrst_idle", 32'({tx_busy_a, tx_line_a}), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
